// File: rtl/uart_cmd_master.sv
// Host-side UART command initiator: frames one command onto a TX byte
// stream, then gathers the response bytes with an inter-byte timeout.
module uart_cmd_master #(
    parameter logic [7:0] WR_CMD      = 8'hAA,
    parameter logic [7:0] RD_CMD      = 8'hBB,
    parameter logic [7:0] ALU_OP_CMD  = 8'hCC,
    parameter logic [7:0] ALU_NOP_CMD = 8'hDD,
    parameter int TIMEOUT_WIDTH = 16,
    parameter logic [TIMEOUT_WIDTH-1:0] TIMEOUT_CYCLES = 16'hFFFF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic [1:0]  CMD_OP,
    input  logic [3:0]  CMD_ADDR,
    input  logic [7:0]  CMD_DATA_A,
    input  logic [7:0]  CMD_DATA_B,
    input  logic [3:0]  CMD_FUN,
    output logic [7:0]  TX_DATA,
    output logic        TX_VALID,
    input  logic        TX_READY,
    input  logic [7:0]  RX_DATA,
    input  logic        RX_VALID,
    output logic [15:0] RSP_DATA,
    output logic        RSP_VALID,
    output logic        RSP_TIMEOUT,
    output logic        BUSY
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_RSP = 2'd2
    } state_t;

    localparam logic [1:0] OP_WR  = 2'b00;
    localparam logic [1:0] OP_RD  = 2'b01;
    localparam logic [1:0] OP_ALU = 2'b10;

    localparam logic [TIMEOUT_WIDTH-1:0] TMO_LIM =
        TIMEOUT_CYCLES - TIMEOUT_WIDTH'(1);

    state_t state;
    state_t state_nxt;

    logic [1:0]  op_q;
    logic [3:0]  addr_q;
    logic [3:0]  fun_q;
    logic [7:0]  a_q;
    logic [7:0]  b_q;
    logic [1:0]  idx_q;
    logic        rx_cnt_q;
    logic [7:0]  rx0_q;
    logic [TIMEOUT_WIDTH-1:0] tmo_q;
    logic [15:0] rsp_data_q;
    logic        rsp_valid_q;
    logic        rsp_timeout_q;

    logic [7:0] frame_byte;
    logic [1:0] last_idx;
    logic       last_byte;
    logic       cmd_fire;
    logic       tx_fire;
    logic       rx_take;
    logic       rx_final;
    logic       expire;

    assign CMD_READY = (state == IDLE);
    assign BUSY      = (state != IDLE);
    assign TX_VALID  = (state == SEND);
    assign TX_DATA   = (state == SEND) ? frame_byte : 8'h00;
    assign RSP_DATA    = rsp_data_q;
    assign RSP_VALID   = rsp_valid_q;
    assign RSP_TIMEOUT = rsp_timeout_q;

    assign cmd_fire  = CMD_VALID && CMD_READY;
    assign tx_fire   = (state == SEND) && TX_READY;
    assign last_byte = (idx_q == last_idx);
    assign rx_take   = (state == WAIT_RSP) && RX_VALID;
    assign rx_final  = rx_take && ((op_q == OP_RD) || rx_cnt_q);
    // A byte arriving on the expiry cycle takes priority over the timeout.
    assign expire    = (state == WAIT_RSP) && !RX_VALID
                       && (tmo_q == TMO_LIM);

    always_comb begin
        last_idx = 2'd1;
        unique case (op_q)
            OP_WR:   last_idx = 2'd2;
            OP_RD:   last_idx = 2'd1;
            OP_ALU:  last_idx = 2'd3;
            default: last_idx = 2'd1;
        endcase
    end

    always_comb begin
        frame_byte = 8'h00;
        unique case (op_q)
            OP_WR: begin
                unique case (idx_q)
                    2'd0:    frame_byte = WR_CMD;
                    2'd1:    frame_byte = {4'h0, addr_q};
                    default: frame_byte = a_q;
                endcase
            end
            OP_RD: begin
                frame_byte = (idx_q == 2'd0) ? RD_CMD : {4'h0, addr_q};
            end
            OP_ALU: begin
                unique case (idx_q)
                    2'd0:    frame_byte = ALU_OP_CMD;
                    2'd1:    frame_byte = a_q;
                    2'd2:    frame_byte = b_q;
                    default: frame_byte = {4'h0, fun_q};
                endcase
            end
            default: begin
                frame_byte = (idx_q == 2'd0) ? ALU_NOP_CMD : {4'h0, fun_q};
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (cmd_fire) state_nxt = SEND;
            end
            SEND: begin
                if (tx_fire && last_byte) begin
                    state_nxt = (op_q == OP_WR) ? IDLE : WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (rx_final || expire) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            op_q          <= 2'b00;
            addr_q        <= 4'h0;
            fun_q         <= 4'h0;
            a_q           <= 8'h00;
            b_q           <= 8'h00;
            idx_q         <= 2'd0;
            rx_cnt_q      <= 1'b0;
            rx0_q         <= 8'h00;
            tmo_q         <= '0;
            rsp_data_q    <= 16'h0000;
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            if (cmd_fire) begin
                op_q     <= CMD_OP;
                addr_q   <= CMD_ADDR;
                fun_q    <= CMD_FUN;
                a_q      <= CMD_DATA_A;
                b_q      <= CMD_DATA_B;
                idx_q    <= 2'd0;
                rx_cnt_q <= 1'b0;
                rx0_q    <= 8'h00;
                tmo_q    <= '0;
            end
            if (tx_fire) begin
                if (last_byte) begin
                    idx_q <= 2'd0;
                    tmo_q <= '0;
                    if (op_q == OP_WR) begin
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= 16'h0000;
                    end
                end else begin
                    idx_q <= idx_q + 2'd1;
                end
            end
            if (rx_take) begin
                tmo_q <= '0;
                if (rx_final) begin
                    rsp_valid_q <= 1'b1;
                    rsp_data_q  <= (op_q == OP_RD) ? {8'h00, RX_DATA}
                                                   : {RX_DATA, rx0_q};
                end else begin
                    rx0_q    <= RX_DATA;
                    rx_cnt_q <= 1'b1;
                end
            end else if (expire) begin
                rsp_timeout_q <= 1'b1;
                rsp_data_q    <= {8'h00, rx0_q};
            end else if (state == WAIT_RSP) begin
                tmo_q <= tmo_q + TIMEOUT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_master.sv
// Bench for uart_cmd_master: directed scenarios plus randomized commands
// checked against a frame/response model built from the protocol rules.
module tb_uart_cmd_master;

    localparam int TMO = 48;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        CMD_VALID = 1'b0;
    logic        CMD_READY;
    logic [1:0]  CMD_OP = 2'b00;
    logic [3:0]  CMD_ADDR = 4'h0;
    logic [7:0]  CMD_DATA_A = 8'h00;
    logic [7:0]  CMD_DATA_B = 8'h00;
    logic [3:0]  CMD_FUN = 4'h0;
    logic [7:0]  TX_DATA;
    logic        TX_VALID;
    logic        TX_READY = 1'b0;
    logic [7:0]  RX_DATA = 8'h00;
    logic        RX_VALID = 1'b0;
    logic [15:0] RSP_DATA;
    logic        RSP_VALID;
    logic        RSP_TIMEOUT;
    logic        BUSY;

    always #5 CLK = ~CLK;

    uart_cmd_master #(.TIMEOUT_CYCLES(16'(TMO))) dut (
        .CLK(CLK), .RST(RST),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_OP(CMD_OP), .CMD_ADDR(CMD_ADDR),
        .CMD_DATA_A(CMD_DATA_A), .CMD_DATA_B(CMD_DATA_B),
        .CMD_FUN(CMD_FUN),
        .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
        .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
        .RSP_DATA(RSP_DATA), .RSP_VALID(RSP_VALID),
        .RSP_TIMEOUT(RSP_TIMEOUT), .BUSY(BUSY)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_frame[$];
    logic [7:0] got[$];
    int n_cyc, n_stab, n_bub;
    logic first_ok;

    // Reference: frame contents by command type.
    function automatic void model_frame(input logic [1:0] op,
        input logic [3:0] addr, input logic [7:0] a, input logic [7:0] b,
        input logic [3:0] fun);
        exp_frame = {};
        case (op)
            2'd0: begin
                exp_frame.push_back(8'hAA);
                exp_frame.push_back({4'h0, addr});
                exp_frame.push_back(a);
            end
            2'd1: begin
                exp_frame.push_back(8'hBB);
                exp_frame.push_back({4'h0, addr});
            end
            2'd2: begin
                exp_frame.push_back(8'hCC);
                exp_frame.push_back(a);
                exp_frame.push_back(b);
                exp_frame.push_back({4'h0, fun});
            end
            default: begin
                exp_frame.push_back(8'hDD);
                exp_frame.push_back({4'h0, fun});
            end
        endcase
    endfunction

    function automatic int rsp_len(input logic [1:0] op);
        return (op == 2'd0) ? 0 : (op == 2'd1) ? 1 : 2;
    endfunction

    function automatic logic [15:0] model_rsp(input logic [1:0] op,
        input logic [7:0] b0, input logic [7:0] b1, input int nd);
        logic [15:0] r;
        r = 16'h0000;
        if (nd >= 1) r[7:0] = b0;
        if (op != 2'd1 && nd >= 2) r[15:8] = b1;
        return r;
    endfunction

    function automatic int frame_diff();
        int d;
        d = (got.size() != exp_frame.size()) ? 1 : 0;
        foreach (got[i])
            if (i < exp_frame.size() && got[i] !== exp_frame[i]) d++;
        return d;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [3:0] addr,
        input logic [7:0] a, input logic [7:0] b, input logic [3:0] fun);
        CMD_OP = op; CMD_ADDR = addr; CMD_DATA_A = a;
        CMD_DATA_B = b; CMD_FUN = fun; CMD_VALID = 1'b1;
        tick();
        CMD_VALID = 1'b0;
        CMD_OP = 2'($urandom); CMD_ADDR = 4'($urandom);
        CMD_DATA_A = 8'($urandom); CMD_DATA_B = 8'($urandom);
        CMD_FUN = 4'($urandom);
    endtask

    task automatic collect_tx(input int mode, input int len, input bit junk);
        logic stalled;
        logic [7:0] prev;
        int budget;
        bit ph;
        stalled = 1'b0; prev = 8'h00; budget = 0; ph = 1'b1;
        got = {}; n_cyc = 0; n_stab = 0; n_bub = 0;
        first_ok = TX_VALID;
        while (got.size() < len && budget < 400) begin
            case (mode)
                0: TX_READY = 1'b1;
                1: begin TX_READY = ph; ph = !ph; end
                default: TX_READY = 1'($urandom_range(0, 1));
            endcase
            if (junk) begin
                RX_VALID = 1'($urandom_range(0, 1));
                RX_DATA = 8'($urandom);
            end
            if (stalled && (!TX_VALID || TX_DATA !== prev)) n_stab++;
            if (!TX_VALID) n_bub++;
            stalled = TX_VALID && !TX_READY;
            prev = TX_DATA;
            if (TX_VALID && TX_READY) got.push_back(TX_DATA);
            n_cyc++;
            budget++;
            tick();
        end
        TX_READY = 1'b0;
        RX_VALID = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b);
        RX_DATA = b;
        RX_VALID = 1'b1;
        tick();
        RX_VALID = 1'b0;
        RX_DATA = 8'($urandom);
    endtask

    task automatic wait_timeout(output int k_to, output int saw_valid);
        k_to = -1;
        saw_valid = 0;
        for (int k = 1; k <= TMO + 20; k++) begin
            tick();
            if (RSP_VALID) saw_valid = 1;
            if (RSP_TIMEOUT) begin
                k_to = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if (CMD_READY !== 1'b1 || TX_VALID !== 1'b0 || TX_DATA !== 8'h00) begin
            errors++;
            $display("FAIL reset_tx: ready=%b txv=%b txd=%h required 1 0 00",
                     CMD_READY, TX_VALID, TX_DATA);
        end
        checks++;
        if (RSP_DATA !== 16'h0 || RSP_VALID !== 1'b0 || RSP_TIMEOUT !== 1'b0
            || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL reset_rsp: data=%h v=%b to=%b busy=%b required 0000 0 0 0",
                     RSP_DATA, RSP_VALID, RSP_TIMEOUT, BUSY);
        end
        RST = 1'b0;
        tick();
    endtask

    task automatic test_write();
        issue(2'd0, 4'h2, 8'h81, 8'h00, 4'h0);
        checks++;
        if (CMD_READY !== 1'b0 || BUSY !== 1'b1) begin
            errors++;
            $display("FAIL wr_busy: ready=%b busy=%b required 0 1", CMD_READY, BUSY);
        end
        model_frame(2'd0, 4'h2, 8'h81, 8'h00, 4'h0);
        collect_tx(0, exp_frame.size(), 1'b0);
        checks++;
        if (frame_diff() != 0 || first_ok !== 1'b1) begin
            errors++;
            $display("FAIL wr_frame: got %p first=%b required %p", got, first_ok, exp_frame);
        end
        checks++;
        if (n_cyc != 3 || n_bub != 0) begin
            errors++;
            $display("FAIL wr_cycles: got %0d cycles %0d bubbles required 3 0", n_cyc, n_bub);
        end
        checks++;
        if (TX_VALID !== 1'b0 || RSP_VALID !== 1'b1 || RSP_DATA !== 16'h0000
            || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL wr_done: txv=%b v=%b data=%h busy=%b required 0 1 0000 0",
                     TX_VALID, RSP_VALID, RSP_DATA, BUSY);
        end
        tick();
        checks++;
        if (RSP_VALID !== 1'b0) begin
            errors++;
            $display("FAIL wr_pulse: rsp_valid=%b required 0", RSP_VALID);
        end
    endtask

    task automatic test_read();
        issue(2'd1, 4'h5, 8'h00, 8'h00, 4'h0);
        model_frame(2'd1, 4'h5, 8'h00, 8'h00, 4'h0);
        collect_tx(0, exp_frame.size(), 1'b0);
        checks++;
        if (frame_diff() != 0) begin
            errors++;
            $display("FAIL rd_frame: got %p required %p", got, exp_frame);
        end
        repeat (39) tick();
        checks++;
        if (RSP_VALID !== 1'b0 || BUSY !== 1'b1) begin
            errors++;
            $display("FAIL rd_wait: v=%b busy=%b required 0 1", RSP_VALID, BUSY);
        end
        send_rx(8'h3C);
        checks++;
        if (RSP_VALID !== 1'b1 || RSP_DATA !== 16'h003C || RSP_TIMEOUT !== 1'b0
            || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL rd_rsp: v=%b data=%h to=%b busy=%b required 1 003c 0 0",
                     RSP_VALID, RSP_DATA, RSP_TIMEOUT, BUSY);
        end
    endtask

    task automatic test_alu_stall();
        issue(2'd2, 4'h0, 8'h0A, 8'h05, 4'h2);
        model_frame(2'd2, 4'h0, 8'h0A, 8'h05, 4'h2);
        collect_tx(1, exp_frame.size(), 1'b0);
        checks++;
        if (frame_diff() != 0 || n_stab != 0) begin
            errors++;
            $display("FAIL alu_frame: got %p unstable=%0d required %p 0",
                     got, n_stab, exp_frame);
        end
        send_rx(8'h32);
        checks++;
        if (RSP_VALID !== 1'b0 || BUSY !== 1'b1) begin
            errors++;
            $display("FAIL alu_mid: v=%b busy=%b required 0 1", RSP_VALID, BUSY);
        end
        send_rx(8'h00);
        checks++;
        if (RSP_VALID !== 1'b1 || RSP_DATA !== 16'h0032) begin
            errors++;
            $display("FAIL alu_rsp: v=%b data=%h required 1 0032", RSP_VALID, RSP_DATA);
        end
    endtask

    task automatic test_timeout();
        int k_to, saw;
        issue(2'd3, 4'h0, 8'h00, 8'h00, 4'h0);
        model_frame(2'd3, 4'h0, 8'h00, 8'h00, 4'h0);
        collect_tx(0, exp_frame.size(), 1'b0);
        checks++;
        if (frame_diff() != 0) begin
            errors++;
            $display("FAIL nop_frame: got %p required %p", got, exp_frame);
        end
        send_rx(8'h11);
        wait_timeout(k_to, saw);
        checks++;
        if (k_to != TMO || saw != 0) begin
            errors++;
            $display("FAIL nop_timeout: after %0d cycles valid_seen=%0d required %0d 0",
                     k_to, saw, TMO);
        end
        checks++;
        if (RSP_DATA !== 16'h0011 || BUSY !== 1'b0 || RSP_VALID !== 1'b0) begin
            errors++;
            $display("FAIL nop_data: data=%h busy=%b v=%b required 0011 0 0",
                     RSP_DATA, BUSY, RSP_VALID);
        end
        tick();
        checks++;
        if (RSP_TIMEOUT !== 1'b0 || RSP_DATA !== 16'h0011) begin
            errors++;
            $display("FAIL nop_pulse: to=%b data=%h required 0 0011", RSP_TIMEOUT, RSP_DATA);
        end
    endtask

    task automatic test_rx_ignore();
        send_rx(8'hEE);
        tick();
        send_rx(8'hEF);
        checks++;
        if (RSP_VALID !== 1'b0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL idle_rx: v=%b busy=%b required 0 0", RSP_VALID, BUSY);
        end
        issue(2'd1, 4'h9, 8'h00, 8'h00, 4'h0);
        model_frame(2'd1, 4'h9, 8'h00, 8'h00, 4'h0);
        collect_tx(2, exp_frame.size(), 1'b1);
        checks++;
        if (frame_diff() != 0 || RSP_VALID !== 1'b0) begin
            errors++;
            $display("FAIL junk_frame: got %p v=%b required %p 0", got, RSP_VALID, exp_frame);
        end
        send_rx(8'h5A);
        checks++;
        if (RSP_VALID !== 1'b1 || RSP_DATA !== 16'h005A) begin
            errors++;
            $display("FAIL junk_rsp: v=%b data=%h required 1 005a", RSP_VALID, RSP_DATA);
        end
        issue(2'd1, 4'h3, 8'h00, 8'h00, 4'h0);
        model_frame(2'd1, 4'h3, 8'h00, 8'h00, 4'h0);
        collect_tx(0, exp_frame.size(), 1'b0);
        repeat (TMO - 1) tick();
        send_rx(8'h77);
        checks++;
        if (RSP_VALID !== 1'b1 || RSP_TIMEOUT !== 1'b0 || RSP_DATA !== 16'h0077) begin
            errors++;
            $display("FAIL expiry_rx: v=%b to=%b data=%h required 1 0 0077",
                     RSP_VALID, RSP_TIMEOUT, RSP_DATA);
        end
        tick();
        checks++;
        if (RSP_TIMEOUT !== 1'b0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL expiry_after: to=%b busy=%b required 0 0", RSP_TIMEOUT, BUSY);
        end
    endtask

    task automatic test_back_to_back();
        issue(2'd0, 4'hA, 8'h3E, 8'h00, 4'h0);
        model_frame(2'd0, 4'hA, 8'h3E, 8'h00, 4'h0);
        collect_tx(0, exp_frame.size(), 1'b0);
        checks++;
        if (CMD_READY !== 1'b1 || RSP_VALID !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready: ready=%b v=%b required 1 1", CMD_READY, RSP_VALID);
        end
        issue(2'd2, 4'h0, 8'hF0, 8'h0F, 4'h9);
        model_frame(2'd2, 4'h0, 8'hF0, 8'h0F, 4'h9);
        collect_tx(0, exp_frame.size(), 1'b0);
        checks++;
        if (frame_diff() != 0 || n_bub != 0) begin
            errors++;
            $display("FAIL b2b_frame: got %p bubbles=%0d required %p 0",
                     got, n_bub, exp_frame);
        end
        send_rx(8'h01);
        send_rx(8'h80);
        checks++;
        if (RSP_VALID !== 1'b1 || RSP_DATA !== 16'h8001) begin
            errors++;
            $display("FAIL b2b_rsp: v=%b data=%h required 1 8001", RSP_VALID, RSP_DATA);
        end
    endtask

    task automatic test_reset_mid_frame();
        int stray;
        issue(2'd0, 4'h6, 8'h05, 8'h00, 4'h0);
        TX_READY = 1'b1;
        tick();
        TX_READY = 1'b0;
        checks++;
        if (TX_VALID !== 1'b1 || TX_DATA !== 8'h06) begin
            errors++;
            $display("FAIL rst_pre: txv=%b txd=%h required 1 06", TX_VALID, TX_DATA);
        end
        RST = 1'b1;
        #1;
        checks++;
        if (TX_VALID !== 1'b0 || BUSY !== 1'b0 || TX_DATA !== 8'h00
            || RSP_VALID !== 1'b0 || RSP_TIMEOUT !== 1'b0 || RSP_DATA !== 16'h0) begin
            errors++;
            $display("FAIL rst_async: txv=%b busy=%b txd=%h v=%b to=%b data=%h required all 0",
                     TX_VALID, BUSY, TX_DATA, RSP_VALID, RSP_TIMEOUT, RSP_DATA);
        end
        tick();
        tick();
        #1;
        RST = 1'b0;
        stray = 0;
        repeat (4) begin
            tick();
            if (RSP_VALID || RSP_TIMEOUT || TX_VALID) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL rst_stray: %0d active cycles required 0", stray);
        end
        issue(2'd1, 4'hC, 8'h00, 8'h00, 4'h0);
        model_frame(2'd1, 4'hC, 8'h00, 8'h00, 4'h0);
        collect_tx(0, exp_frame.size(), 1'b0);
        checks++;
        if (frame_diff() != 0) begin
            errors++;
            $display("FAIL rst_frame: got %p required %p", got, exp_frame);
        end
        send_rx(8'hA5);
        checks++;
        if (RSP_VALID !== 1'b1 || RSP_DATA !== 16'h00A5) begin
            errors++;
            $display("FAIL rst_rsp: v=%b data=%h required 1 00a5", RSP_VALID, RSP_DATA);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 30; it++) begin
            logic [1:0] op;
            logic [3:0] addr, fun;
            logic [7:0] a, b;
            logic [7:0] rb[2];
            logic [15:0] exp_rsp;
            int nb, nd, k_to, saw;
            op = 2'($urandom); addr = 4'($urandom); fun = 4'($urandom);
            a = 8'($urandom); b = 8'($urandom);
            rb[0] = 8'($urandom); rb[1] = 8'($urandom);
            checks++;
            if (CMD_READY !== 1'b1) begin
                errors++;
                $display("FAIL rnd_ready[%0d]: ready=%b required 1", it, CMD_READY);
            end
            issue(op, addr, a, b, fun);
            model_frame(op, addr, a, b, fun);
            collect_tx(2, exp_frame.size(), 1'($urandom_range(0, 1)));
            checks++;
            if (frame_diff() != 0 || n_stab != 0) begin
                errors++;
                $display("FAIL rnd_frame[%0d]: got %p unstable=%0d required %p 0",
                         it, got, n_stab, exp_frame);
            end
            nb = rsp_len(op);
            if (nb == 0) begin
                checks++;
                if (RSP_VALID !== 1'b1 || RSP_DATA !== 16'h0000) begin
                    errors++;
                    $display("FAIL rnd_wr[%0d]: v=%b data=%h required 1 0000",
                             it, RSP_VALID, RSP_DATA);
                end
            end else begin
                nd = ($urandom_range(0, 3) == 0) ? $urandom_range(0, nb - 1) : nb;
                for (int j = 0; j < nd; j++) begin
                    repeat ($urandom_range(0, TMO - 1)) tick();
                    send_rx(rb[j]);
                end
                exp_rsp = model_rsp(op, rb[0], rb[1], nd);
                if (nd == nb) begin
                    checks++;
                    if (RSP_VALID !== 1'b1 || RSP_TIMEOUT !== 1'b0 || RSP_DATA !== exp_rsp) begin
                        errors++;
                        $display("FAIL rnd_rsp[%0d]: v=%b to=%b data=%h required 1 0 %h",
                                 it, RSP_VALID, RSP_TIMEOUT, RSP_DATA, exp_rsp);
                    end
                end else begin
                    wait_timeout(k_to, saw);
                    checks++;
                    if (k_to != TMO || saw != 0 || RSP_DATA !== exp_rsp) begin
                        errors++;
                        $display("FAIL rnd_to[%0d]: after %0d v_seen=%0d data=%h required %0d 0 %h",
                                 it, k_to, saw, RSP_DATA, TMO, exp_rsp);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_alu_stall();
        test_timeout();
        test_rx_ignore();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
